// File: rtl/uart_mmio.sv
// Memory-mapped UART bridge for the Riscv151 data port: status/RX/TX registers,
// an RX byte FIFO, a single-byte TX holding register and cycle/instruction counters.
module uart_mmio #(
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  we,
  input  logic        re,
  output logic [31:0] rdata,
  input  logic        inst_retired,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);

  localparam int AW = $clog2(RX_FIFO_DEPTH);

  localparam logic [7:0] OFF_STATUS  = 8'h00;
  localparam logic [7:0] OFF_RX_DATA = 8'h04;
  localparam logic [7:0] OFF_TX_DATA = 8'h08;
  localparam logic [7:0] OFF_CYCLES  = 8'h10;
  localparam logic [7:0] OFF_INSTS   = 8'h14;
  localparam logic [7:0] OFF_CNT_RST = 8'h18;

  logic [7:0]  rx_mem [RX_FIFO_DEPTH];
  logic [AW:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic        tx_full_q, tx_full_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic [31:0] cyc_q, cyc_d, inst_q, inst_d;
  logic [31:0] rdata_q, rdata_d;

  logic        sel, store, fifo_empty, fifo_full, push, pop;
  logic [7:0]  offset, rx_head;
  logic [31:0] read_val;

  assign sel        = (addr[31:28] == 4'h8);
  assign offset     = addr[7:0];
  assign store      = sel && (we != 4'b0000);
  assign fifo_empty = (rd_ptr_q == wr_ptr_q);
  // Same slot index with differing wrap bits means the writer is a full lap ahead.
  assign fifo_full  = (rd_ptr_q[AW] != wr_ptr_q[AW]) &&
                      (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]);
  assign rx_head    = rx_mem[rd_ptr_q[AW-1:0]];

  assign uart_rx_ready = !fifo_full && !rst;
  assign push          = uart_rx_valid && uart_rx_ready;
  assign pop           = sel && re && (offset == OFF_RX_DATA) && !fifo_empty;

  assign uart_tx_valid = tx_full_q && !rst;
  assign uart_tx_data  = rst ? 8'h00 : tx_byte_q;
  assign rdata         = rst ? 32'h0 : rdata_q;

  always_comb begin
    read_val = 32'h0;
    if (sel) begin
      case (offset)
        OFF_STATUS:  read_val = {30'b0, !fifo_empty, !tx_full_q};
        OFF_RX_DATA: read_val = fifo_empty ? 32'h0 : {24'b0, rx_head};
        OFF_CYCLES:  read_val = cyc_q;
        OFF_INSTS:   read_val = inst_q;
        default:     read_val = 32'h0;
      endcase
    end
  end

  always_comb begin
    rdata_d   = re ? read_val : rdata_q;
    rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    tx_full_d = tx_full_q;
    tx_byte_d = tx_byte_q;
    // Occupancy is judged on the pre-edge state, so a store in the draining cycle is lost.
    if (tx_full_q) begin
      if (uart_tx_ready) tx_full_d = 1'b0;
    end else if (store && (offset == OFF_TX_DATA)) begin
      tx_full_d = 1'b1;
      tx_byte_d = wdata[7:0];
    end
    if (store && (offset == OFF_CNT_RST)) begin
      cyc_d  = 32'h0;
      inst_d = 32'h0;
    end else begin
      cyc_d  = cyc_q + 32'd1;
      inst_d = inst_q + {31'b0, inst_retired};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q   <= 32'h0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      tx_full_q <= 1'b0;
      tx_byte_q <= 8'h00;
      cyc_q     <= 32'h0;
      inst_q    <= 32'h0;
    end else begin
      rdata_q   <= rdata_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      tx_full_q <= tx_full_d;
      tx_byte_q <= tx_byte_d;
      cyc_q     <= cyc_d;
      inst_q    <= inst_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) rx_mem[wr_ptr_q[AW-1:0]] <= uart_rx_data;
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Randomized and directed bench for uart_mmio against a queue-based register model.
module tb_uart_mmio;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  we;
  logic        re, inst_retired;
  logic [7:0]  uart_tx_data, uart_rx_data;
  logic        uart_tx_valid, uart_tx_ready, uart_rx_valid, uart_rx_ready;

  always #5 clk = ~clk;

  uart_mmio #(.RX_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .rdata(rdata), .inst_retired(inst_retired),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [7:0]  m_fifo[$];
  bit          m_tx_full;
  logic [7:0]  m_tx_byte;
  logic [31:0] m_cyc, m_inst, m_rdata;
  logic [7:0]  src[$];
  logic [7:0]  tx_log[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a[31:28] != 4'h8) return 32'h0;
    case (a[7:0])
      8'h00: return {30'b0, m_fifo.size() > 0, !m_tx_full};
      8'h04: return (m_fifo.size() > 0) ? {24'b0, m_fifo[0]} : 32'h0;
      8'h10: return m_cyc;
      8'h14: return m_inst;
      default: return 32'h0;
    endcase
  endfunction

  // One clock: update model from pre-edge inputs, clock, then compare outputs.
  task automatic tick();
    bit sel, wr, do_pop, do_push;
    logic [7:0] off;
    uart_rx_valid = (src.size() > 0);
    uart_rx_data  = (src.size() > 0) ? src[0] : 8'h00;
    #1;
    if (uart_rx_valid && uart_rx_ready) void'(src.pop_front());
    if (uart_tx_valid && uart_tx_ready) tx_log.push_back(uart_tx_data);
    if (rst) begin
      m_fifo.delete();
      m_tx_full = 0; m_tx_byte = 8'h00; m_cyc = 0; m_inst = 0; m_rdata = 0;
    end else begin
      off = addr[7:0];
      sel = (addr[31:28] == 4'h8);
      wr  = sel && (we != 4'b0);
      if (re) m_rdata = model_read(addr);
      do_pop  = re && sel && (off == 8'h04) && (m_fifo.size() > 0);
      do_push = uart_rx_valid && (m_fifo.size() < DEPTH);
      if (do_pop) void'(m_fifo.pop_front());
      if (do_push) m_fifo.push_back(uart_rx_data);
      if (m_tx_full) begin
        if (uart_tx_ready) m_tx_full = 0;
      end else if (wr && off == 8'h08) begin
        m_tx_full = 1; m_tx_byte = wdata[7:0];
      end
      if (wr && off == 8'h18) begin
        m_cyc = 0; m_inst = 0;
      end else begin
        m_cyc = m_cyc + 1; m_inst = m_inst + {31'b0, inst_retired};
      end
    end
    @(posedge clk); #1;
    check_eq("rdata", rdata, rst ? 32'h0 : m_rdata);
    check_eq("tx_valid", {31'b0, uart_tx_valid}, {31'b0, m_tx_full && !rst});
    if (m_tx_full && !rst) check_eq("tx_data", {24'b0, uart_tx_data}, {24'b0, m_tx_byte});
    check_eq("rx_ready", {31'b0, uart_rx_ready}, {31'b0, (m_fifo.size() < DEPTH) && !rst});
  endtask

  task automatic do_load(input logic [31:0] a, output logic [31:0] d);
    addr = a; re = 1'b1; we = 4'b0;
    tick();
    d = rdata; re = 1'b0;
    $display("load  0x%08h -> 0x%08h", a, d);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] dt);
    addr = a; wdata = dt; we = 4'hF; re = 1'b0;
    tick();
    we = 4'b0;
    $display("store 0x%08h <- 0x%08h", a, dt);
  endtask

  task automatic do_reset();
    rst = 1'b1; src.delete();
    #1;
    check_eq("rx_ready_in_rst", {31'b0, uart_rx_ready}, 32'h0);
    tick();
    rst = 1'b0;
  endtask

  logic [31:0] d;
  logic [31:0] rand_addrs [8] = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_0010,
                                  32'h8000_0014, 32'h8000_0018, 32'h8000_000C, 32'h0000_0004};

  initial begin
    rst = 1'b1; addr = 0; wdata = 0; we = 0; re = 0; inst_retired = 0;
    uart_tx_ready = 0; uart_rx_valid = 0; uart_rx_data = 0;
    m_tx_byte = 0; m_cyc = 0; m_inst = 0; m_rdata = 0; m_tx_full = 0;

    do_reset();
    do_load(32'h8000_0000, d); check_eq("plan_status_idle", d, 32'h1);
    check_eq("plan_tx_valid_idle", {31'b0, uart_tx_valid}, 32'h0);
    check_eq("plan_rx_ready_idle", {31'b0, uart_rx_ready}, 32'h1);

    src.push_back(8'h7A); tick();
    do_load(32'h8000_0000, d); check_eq("plan_status_rx", d, 32'h3);
    do_load(32'h8000_0004, d); check_eq("plan_rx_byte", d, 32'h7A);
    do_load(32'h8000_0000, d); check_eq("plan_status_rx_drained", d, 32'h1);

    uart_tx_ready = 1'b0;
    do_store(32'h8000_0008, 32'h7A);
    check_eq("plan_tx_valid", {31'b0, uart_tx_valid}, 32'h1);
    check_eq("plan_tx_data", {24'b0, uart_tx_data}, 32'h7A);
    do_load(32'h8000_0000, d); check_eq("plan_status_tx_full", d, 32'h0);
    do_store(32'h8000_0008, 32'h55);
    check_eq("plan_tx_data_kept", {24'b0, uart_tx_data}, 32'h7A);
    uart_tx_ready = 1'b1; tick(); uart_tx_ready = 1'b0;
    check_eq("plan_tx_drained", {31'b0, uart_tx_valid}, 32'h0);
    do_load(32'h8000_0000, d); check_eq("plan_status_tx_empty", d, 32'h1);
    tick(); tick();
    check_eq("plan_tx_count", tx_log.size(), 32'd1);
    if (tx_log.size() > 0) check_eq("plan_tx_byte_sent", {24'b0, tx_log[0]}, 32'h7A);

    for (int i = 1; i <= 5; i++) src.push_back(i[7:0]);
    for (int i = 0; i < 4; i++) tick();
    check_eq("plan_fifo_full", {31'b0, uart_rx_ready}, 32'h0);
    tick(); tick();
    check_eq("plan_src_holds", src.size(), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      do_load(32'h8000_0004, d); check_eq("plan_fifo_order", d, i);
    end
    do_load(32'h8000_0004, d); check_eq("plan_fifo_empty_read", d, 32'h0);
    do_load(32'h8000_0000, d); check_eq("plan_status_after_fifo", d, 32'h1);

    do_reset();
    for (int i = 0; i < 100; i++) begin
      inst_retired = (i % 2 == 0);
      tick();
    end
    inst_retired = 1'b0;
    do_load(32'h8000_0010, d); check_eq("plan_cycles_100", d, 32'd100);
    do_load(32'h8000_0014, d); check_eq("plan_insts_50", d, 32'd50);
    do_store(32'h8000_0018, 32'h0);
    do_load(32'h8000_0010, d); check_eq("plan_cycles_cleared", d, 32'h0);
    do_load(32'h8000_0010, d); check_eq("plan_cycles_after_clear", d, 32'h1);

    do_store(32'h8000_0008, 32'h33);
    src.push_back(8'hA1); src.push_back(8'hA2); tick(); tick(); tick();
    do_load(32'h8000_0000, d); check_eq("plan_status_busy", d, 32'h2);
    do_reset();
    do_load(32'h8000_0010, d); check_eq("plan_rst_cycles", d, 32'h0);
    do_load(32'h8000_0014, d); check_eq("plan_rst_insts", d, 32'h0);
    check_eq("plan_rst_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
    do_load(32'h8000_0000, d); check_eq("plan_rst_status", d, 32'h1);
    do_load(32'h8000_0004, d); check_eq("plan_rst_rx_empty", d, 32'h0);

    for (int i = 0; i < 600; i++) begin
      rst           = ($urandom_range(0, 99) == 0);
      re            = $urandom_range(0, 1);
      we            = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
      addr          = rand_addrs[$urandom_range(0, 7)];
      if ($urandom_range(0, 9) == 0) addr[31:28] = 4'h9;
      wdata         = $urandom;
      uart_tx_ready = $urandom_range(0, 1);
      inst_retired  = $urandom_range(0, 1);
      if (src.size() < 3 && $urandom_range(0, 2) == 0) src.push_back(8'($urandom));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
